// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage write-buffer controller.
// Entry layout, FSM states and the word-address helper live here.
package dmem_pkg;
   localparam int unsigned WB_DEPTH = 4;
   localparam int unsigned RAM_LAT  = 5;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      READ
   } state_t;

   typedef struct packed {
      logic [29:0] wa;
      logic [31:0] data;
   } wbuf_entry_t;

   function automatic logic [29:0] word_addr(input logic [31:0] a);
      return a[31:2];
   endfunction
endpackage

// File: rtl/dmem_wbuf_ctrl_if.sv
// Cache-side and RAM-side bundle of the write-buffer controller.
// slave = controller view, master = cache plus RAM view.
interface dmem_wbuf_ctrl_if;
   logic        c_strobe;
   logic        c_rw;
   logic [31:0] c_a;
   logic [31:0] c_din;
   logic        c_ready;
   logic [31:0] c_dout;
   logic [31:0] mem_a;
   logic        mem_we;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        wb_empty;
   logic        wb_full;

   modport slave (
      input  c_strobe, c_rw, c_a, c_din, mem_dout,
      output c_ready, c_dout, mem_a, mem_we, mem_din,
      output wb_empty, wb_full
   );

   modport master (
      output c_strobe, c_rw, c_a, c_din, mem_dout,
      input  c_ready, c_dout, mem_a, mem_we, mem_din,
      input  wb_empty, wb_full
   );
endinterface

// File: rtl/dmem_wbuf_ctrl_wbuf_fifo.sv
// Circular store buffer with push/pop and a youngest-match lookup.
// Entries are kept in program order from head (oldest) to tail.
module wbuf_fifo
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  wbuf_entry_t push_entry,
   input  logic [29:0] look_wa,
   output logic        look_hit,
   output logic [31:0] look_data,
   output wbuf_entry_t head_entry,
   output logic        empty,
   output logic        full
);
   localparam int unsigned PW = $clog2(DEPTH);

   wbuf_entry_t   mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + 1'b1;
         if (pop)
            head <= head + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[tail] <= push_entry;
   end

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      look_hit  = 1'b0;
      look_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((PW+1)'(i) < count &&
             mem[head + PW'(i)].wa == look_wa) begin
            look_hit  = 1'b1;
            look_data = mem[head + PW'(i)].data;
         end
      end
   end

   assign head_entry = mem[head];
   assign empty      = (count == '0);
   assign full       = (count == (PW+1)'(DEPTH));
endmodule

// File: rtl/dmem_wbuf_ctrl.sv
// Memory-side controller: posts stores, drains them to RAM,
// and serves read misses from RAM or by forwarding from the buffer.
module dmem_wbuf_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = WB_DEPTH,
   parameter int unsigned MEM_LAT = RAM_LAT
) (
   input logic              clock,
   input logic              reset,
   dmem_wbuf_ctrl_if.slave  bus
);
   localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   logic        wr_req;
   logic        rd_req;
   logic        push;
   logic        pop;
   logic        hit;
   logic [31:0] hit_data;
   logic        empty;
   logic        full;
   wbuf_entry_t head_e;
   wbuf_entry_t new_e;

   assign wr_req = bus.c_strobe & bus.c_rw;
   assign rd_req = bus.c_strobe & ~bus.c_rw;
   assign pop    = (state == DRAIN) && (cnt == LAST);
   // A full buffer still takes a store in the cycle its head retires.
   assign push   = wr_req & (~full | pop);
   assign new_e  = '{wa: word_addr(bus.c_a), data: bus.c_din};

   wbuf_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .push_entry (new_e),
      .look_wa    (word_addr(bus.c_a)),
      .look_hit   (hit),
      .look_data  (hit_data),
      .head_entry (head_e),
      .empty      (empty),
      .full       (full)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bus.c_ready = 1'b0;
      bus.c_dout  = '0;
      bus.mem_a   = '0;
      bus.mem_we  = 1'b0;
      bus.mem_din = '0;

      if (push)
         bus.c_ready = 1'b1;
      if (rd_req && hit) begin
         bus.c_ready = 1'b1;
         bus.c_dout  = hit_data;
      end

      unique case (state)
         IDLE: begin
            // Reads beat draining.
            if (rd_req && !hit) begin
               state_nxt = READ;
               cnt_nxt   = '0;
            end else if (!empty) begin
               state_nxt = DRAIN;
               cnt_nxt   = '0;
            end
         end
         DRAIN: begin
            bus.mem_a   = {head_e.wa, 2'b00};
            bus.mem_din = head_e.data;
            if (cnt == LAST) begin
               bus.mem_we = 1'b1;
               state_nxt  = IDLE;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         READ: begin
            bus.mem_a = {word_addr(bus.c_a), 2'b00};
            if (cnt == LAST) begin
               bus.c_ready = rd_req;
               bus.c_dout  = rd_req ? bus.mem_dout : '0;
               state_nxt   = IDLE;
               cnt_nxt     = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign bus.wb_empty = empty;
   assign bus.wb_full  = full;
endmodule

// File: tb/tb_dmem_wbuf_ctrl.sv
// Directed bench for dmem_wbuf_ctrl with a scoreboard on c_ready.
// The bench models the cache driver and a word RAM.
module tb_dmem_wbuf_ctrl;
   import dmem_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LAT   = 5;

   typedef struct {
      logic        rw;
      logic [31:0] a;
      logic [31:0] d;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   we_cnt = 0;
   logic ram_init = 1'b0;
   logic [31:0] ram [0:1023];
   exp_t sb [$];
   exp_t me;

   dmem_wbuf_ctrl_if bus ();

   dmem_wbuf_ctrl #(
      .DEPTH   (DEPTH),
      .MEM_LAT (LAT)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_dout = ram[bus.mem_a[11:2]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!ram_init) begin
         for (int i = 0; i < 1024; i++)
            ram[i] <= 32'h0;
         ram[32'h200 >> 2] <= 32'h1234_5678;
         ram[32'h300 >> 2] <= 32'hCAFE_F00D;
         ram[32'h404 >> 2] <= 32'hDEAD_0404;
         ram[32'h500 >> 2] <= 32'h0000_5555;
         ram_init <= 1'b1;
      end else if (bus.mem_we) begin
         ram[bus.mem_a[11:2]] <= bus.mem_din;
         we_cnt <= we_cnt + 1;
      end
   end

   // Scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.c_ready) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected cyc=%0d a=%h ready=1 want no ready",
                        cyc, bus.c_a);
            end else begin
               me = sb.pop_front();
               if (bus.c_strobe !== 1'b1 || bus.c_rw !== me.rw ||
                   bus.c_a !== me.a ||
                   (!me.rw && bus.c_dout !== me.d) ||
                   (me.cyc >= 0 && cyc != me.cyc)) begin
                  fails++;
                  $display("FAIL sb_req a=%h got rw=%0b dout=%h cyc=%0d want rw=%0b dout=%h cyc=%0d",
                           bus.c_a, bus.c_rw, bus.c_dout, cyc,
                           me.rw, me.d, me.cyc);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d want finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      return ram[a[11:2]];
   endfunction

   task automatic do_req(input logic rw, input logic [31:0] a,
                         input logic [31:0] d, input int lat,
                         input logic [31:0] exp_d);
      exp_t e;
      int   n;
      e.rw  = rw;
      e.a   = a;
      e.d   = exp_d;
      e.cyc = (lat < 0) ? -1 : cyc + lat;
      sb.push_back(e);
      bus.c_strobe = 1'b1;
      bus.c_rw     = rw;
      bus.c_a      = a;
      bus.c_din    = d;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.c_ready === 1'b1)
            break;
         n++;
         if (n > 100) begin
            tests++;
            fails++;
            $display("FAIL req_timeout a=%h got no ready want ready", a);
            void'(sb.pop_back());
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.c_strobe = 1'b0;
      bus.c_rw     = 1'b0;
      bus.c_din    = '0;
   endtask

   task automatic wait_drained();
      int n = 0;
      while (bus.wb_empty !== 1'b1 && n < 300) begin
         tick(1);
         n++;
      end
      if (n >= 300) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout got wb_empty=%b want 1", bus.wb_empty);
      end
      tick(2);
   endtask

   initial begin
      int t0;
      int w0;
      bus.c_strobe = 1'b0;
      bus.c_rw     = 1'b0;
      bus.c_a      = '0;
      bus.c_din    = '0;
      rst = 1'b1;
      tick(2);
      @(negedge clk);
      check("rst_c_ready", 32'(bus.c_ready), 32'h0);
      check("rst_c_dout", bus.c_dout, 32'h0);
      check("rst_mem_we", 32'(bus.mem_we), 32'h0);
      check("rst_mem_a", bus.mem_a, 32'h0);
      check("rst_mem_din", bus.mem_din, 32'h0);
      check("rst_wb_empty", 32'(bus.wb_empty), 32'h1);
      check("rst_wb_full", 32'(bus.wb_full), 32'h0);
      tick(1);
      rst = 1'b0;
      tick(1);

      // Fill to full, fifth store waits for the first retirement
      t0 = cyc;
      w0 = we_cnt;
      for (int i = 0; i < 4; i++)
         do_req(1'b1, 32'h40 + 32'(4*i), 32'h1000 + 32'(i), 0, 32'h0);
      check("full_after_4", 32'(bus.wb_full), 32'h1);
      do_req(1'b1, 32'h50, 32'h1004, (t0 + LAT + 1) - cyc, 32'h0);
      wait_drained();
      for (int i = 0; i < 5; i++)
         check("fill_ram", rd(32'h40 + 32'(4*i)), 32'h1000 + 32'(i));
      check("fill_we_cnt", 32'(we_cnt - w0), 32'd5);

      // Forwarding picks the youngest duplicate
      w0 = we_cnt;
      do_req(1'b1, 32'h100, 32'hAAAA, 0, 32'h0);
      do_req(1'b1, 32'h100, 32'hBBBB, 0, 32'h0);
      do_req(1'b0, 32'h100, 32'h0, 0, 32'hBBBB);
      check("fwd_no_we_yet", 32'(we_cnt - w0), 32'd0);
      check("fwd_not_empty", 32'(bus.wb_empty), 32'h0);
      wait_drained();
      check("fwd_ram", rd(32'h100), 32'hBBBB);
      check("fwd_we_cnt", 32'(we_cnt - w0), 32'd2);

      // Read miss on an idle controller
      do_req(1'b0, 32'h200, 32'h0, LAT, 32'h1234_5678);

      // Read miss during a drain is served before the second store
      do_req(1'b1, 32'h400, 32'h11, 0, 32'h0);
      do_req(1'b1, 32'h404, 32'h22, 0, 32'h0);
      tick(1);
      do_req(1'b0, 32'h300, 32'h0, 2*LAT - 1, 32'hCAFE_F00D);
      check("mix_first_drained", rd(32'h400), 32'h11);
      check("mix_second_pending", rd(32'h404), 32'hDEAD_0404);
      wait_drained();
      check("mix_second_drained", rd(32'h404), 32'h22);

      // Same-address stores drain in program order
      w0 = we_cnt;
      do_req(1'b1, 32'h40, 32'h1, 0, 32'h0);
      do_req(1'b1, 32'h40, 32'h2, 0, 32'h0);
      wait_drained();
      check("order_ram", rd(32'h40), 32'h2);
      check("order_we_cnt", 32'(we_cnt - w0), 32'd2);

      // Reset on the write-enable cycle of a drain
      w0 = we_cnt;
      do_req(1'b1, 32'h500, 32'h5, 0, 32'h0);
      do_req(1'b1, 32'h504, 32'h6, 0, 32'h0);
      do_req(1'b1, 32'h508, 32'h7, 0, 32'h0);
      tick(3);
      check("pre_rst_we", 32'(bus.mem_we), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_we", 32'(bus.mem_we), 32'h0);
      tick(1);
      rst = 1'b0;
      tick(3*LAT);
      check("rst_mid_empty", 32'(bus.wb_empty), 32'h1);
      check("rst_mid_full", 32'(bus.wb_full), 32'h0);
      check("rst_mid_ram", rd(32'h500), 32'h5555);
      check("rst_mid_we_cnt", 32'(we_cnt - w0), 32'd0);

      check("sb_leftover", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
